// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if: game-control inputs and playfield outputs of the pipe scroller.
interface pipe_scroller_if;
  logic        frame_tick;
  logic        start;
  logic        halt;
  logic [31:0] pipe1x, pipe2x, pipe3x, pipe4x;
  logic [31:0] pipe1ycenter, pipe2ycenter, pipe3ycenter, pipe4ycenter;
  logic [31:0] pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace;
  logic [31:0] current_score;
  logic        running;
  modport master (
    output frame_tick, start, halt,
    input  pipe1x, pipe2x, pipe3x, pipe4x,
    input  pipe1ycenter, pipe2ycenter, pipe3ycenter, pipe4ycenter,
    input  pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace,
    input  current_score, running
  );
  modport slave (
    input  frame_tick, start, halt,
    output pipe1x, pipe2x, pipe3x, pipe4x,
    output pipe1ycenter, pipe2ycenter, pipe3ycenter, pipe4ycenter,
    output pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace,
    output current_score, running
  );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller: four scrolling pipes with LFSR gap placement, scoring and run/stop control.
module pipe_scroller #(
  parameter int         SCREEN_WIDTH   = 640,
  parameter int         PIPE_WIDTH     = 57,
  parameter int         PIPE_SPACING   = 160,
  parameter int         SCROLL_SPEED   = 2,
  parameter int         GAP_MIN_Y      = 160,
  parameter int         GAP_HEIGHT     = 100,
  parameter int         BIRD_LEFT_EDGE = 60,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input logic clk,
  input logic reset,
  pipe_scroller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_x [4];
  logic [31:0] r_y [4];
  logic [31:0] r_space, r_score;
  logic [7:0]  r_lfsr;
  logic        r_running;
  logic [31:0] w_nx [4];
  logic [31:0] w_ny [4];
  logic [31:0] w_ix [4];
  logic [31:0] w_iy [4];
  logic [7:0]  w_l, w_il;
  logic [3:0]  w_rsp, w_pass;
  logic [2:0]  w_cnt;
  logic [32:0] w_sum;
  logic        w_init, w_tick;
  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == RUN) ? (bus.halt ? STOPPED : RUN) : (bus.start ? RUN : r_state);
    w_init = (r_state != RUN) && bus.start;
    w_tick = (r_state == RUN) && bus.frame_tick && !bus.halt;
  end
  // LFSR values are threaded through the pipes in index order for both init and respawn
  always_comb begin
    w_l = r_lfsr;
    w_il = LFSR_SEED;
    w_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      w_ix[i] = 32'(SCREEN_WIDTH + i * PIPE_SPACING);
      w_iy[i] = 32'(GAP_MIN_Y) + 32'(w_il >> 1);
      w_il = step(w_il);
      w_rsp[i] = r_x[i] < 32'(SCROLL_SPEED);
      w_nx[i] = w_rsp[i] ? r_x[i] + 32'(4 * PIPE_SPACING - SCROLL_SPEED) : r_x[i] - 32'(SCROLL_SPEED);
      w_ny[i] = w_rsp[i] ? 32'(GAP_MIN_Y) + 32'(w_l >> 1) : r_y[i];
      w_l = w_rsp[i] ? step(w_l) : w_l;
      w_pass[i] = !w_rsp[i] && (r_x[i] + 32'(PIPE_WIDTH) >= 32'(BIRD_LEFT_EDGE))
                  && (w_nx[i] + 32'(PIPE_WIDTH) < 32'(BIRD_LEFT_EDGE));
      w_cnt = w_cnt + 3'(w_pass[i]);
    end
    w_sum = {1'b0, r_score} + 33'(w_cnt);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_running <= 1'b0;
      r_x <= '{default: '0};
      r_y <= '{default: '0};
      r_space <= '0;
      r_score <= '0;
      r_lfsr <= LFSR_SEED;
    end else begin
      r_running <= (w_next == RUN);
      if (w_init) begin
        r_x <= w_ix;
        r_y <= w_iy;
        r_space <= 32'(GAP_HEIGHT);
        r_score <= '0;
        r_lfsr <= w_il;
      end else if (w_tick) begin
        r_x <= w_nx;
        r_y <= w_ny;
        r_score <= w_sum[32] ? '1 : w_sum[31:0];
        r_lfsr <= w_l;
      end
    end
  end
  assign bus.pipe1x = r_x[0];
  assign bus.pipe2x = r_x[1];
  assign bus.pipe3x = r_x[2];
  assign bus.pipe4x = r_x[3];
  assign bus.pipe1ycenter = r_y[0];
  assign bus.pipe2ycenter = r_y[1];
  assign bus.pipe3ycenter = r_y[2];
  assign bus.pipe4ycenter = r_y[3];
  assign bus.pipe1yspace = r_space;
  assign bus.pipe2yspace = r_space;
  assign bus.pipe3yspace = r_space;
  assign bus.pipe4yspace = r_space;
  assign bus.current_score = r_score;
  assign bus.running = r_running;
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: checks pipe_scroller against a game-level model plus hand-computed checkpoints.
module tb_pipe_scroller;
  logic clk = 0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic en = 0;
  pipe_scroller_if bus ();
  pipe_scroller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int          m_mode;
  longint      m_x [4];
  longint      m_y [4];
  longint      m_sp, m_score;
  logic [7:0]  m_lf;
  logic [31:0] ox [4];
  logic [31:0] oy [4];
  logic [31:0] os [4];
  assign ox = '{bus.pipe1x, bus.pipe2x, bus.pipe3x, bus.pipe4x};
  assign oy = '{bus.pipe1ycenter, bus.pipe2ycenter, bus.pipe3ycenter, bus.pipe4ycenter};
  assign os = '{bus.pipe1yspace, bus.pipe2yspace, bus.pipe3yspace, bus.pipe4yspace};
  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
    end
  endtask
  // game rules: mode 0 idle, 1 run, 2 stopped
  task automatic model_step(input logic f, input logic s, input logic h, input logic r);
    longint nx;
    if (r) begin
      m_mode = 0;
      m_lf = 8'hA5;
      m_sp = 0;
      m_score = 0;
      for (int i = 0; i < 4; i++) begin m_x[i] = 0; m_y[i] = 0; end
    end else if (m_mode != 1 && s) begin
      m_mode = 1;
      m_lf = 8'hA5;
      m_sp = 100;
      m_score = 0;
      for (int i = 0; i < 4; i++) begin
        m_x[i] = 640 + i * 160;
        m_y[i] = 160 + m_lf / 2;
        m_lf = nxt(m_lf);
      end
    end else if (m_mode == 1 && h) begin
      m_mode = 2;
    end else if (m_mode == 1 && f) begin
      for (int i = 0; i < 4; i++) begin
        if (m_x[i] < 2) begin
          m_x[i] = m_x[i] + 640 - 2;
          m_y[i] = 160 + m_lf / 2;
          m_lf = nxt(m_lf);
        end else begin
          nx = m_x[i] - 2;
          if (m_x[i] + 57 >= 60 && nx + 57 < 60 && m_score < 64'hFFFF_FFFF) m_score++;
          m_x[i] = nx;
        end
      end
    end
  endtask
  always @(negedge clk) if (en) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("x%0d", i + 1), ox[i], 32'(m_x[i]));
      chk($sformatf("ycenter%0d", i + 1), oy[i], 32'(m_y[i]));
      chk($sformatf("yspace%0d", i + 1), os[i], 32'(m_sp));
    end
    chk("score", bus.current_score, 32'(m_score));
    chk("running", 32'(bus.running), 32'(m_mode == 1));
  end
  task automatic cyc(input logic f, input logic s, input logic h, input logic r);
    bus.frame_tick = f;
    bus.start = s;
    bus.halt = h;
    reset = r;
    @(posedge clk);
    model_step(f, s, h, r);
    #1;
  endtask
  task automatic tick();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask
  task automatic lit_init(input string tag);
    chk({tag, "_run"}, 32'(bus.running), 1);
    chk({tag, "_x1"}, bus.pipe1x, 640);
    chk({tag, "_x2"}, bus.pipe2x, 800);
    chk({tag, "_x3"}, bus.pipe3x, 960);
    chk({tag, "_x4"}, bus.pipe4x, 1120);
    chk({tag, "_y1"}, bus.pipe1ycenter, 242);
    chk({tag, "_y2"}, bus.pipe2ycenter, 197);
    chk({tag, "_y3"}, bus.pipe3ycenter, 234);
    chk({tag, "_y4"}, bus.pipe4ycenter, 181);
    chk({tag, "_sp1"}, bus.pipe1yspace, 100);
    chk({tag, "_sp4"}, bus.pipe4yspace, 100);
    chk({tag, "_score"}, bus.current_score, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 1);
    en = 1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("idle_x1", bus.pipe1x, 0);
    chk("idle_run", 32'(bus.running), 0);
    cyc(1, 0, 1, 0);
    chk("idle_ignore_x1", bus.pipe1x, 0);
    cyc(0, 1, 0, 0);
    lit_init("start");
    cyc(0, 0, 0, 0);
    for (int t = 1; t <= 318; t++) begin
      cyc(1, t == 10, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("t318_x1", bus.pipe1x, 4);
    chk("t318_score", bus.current_score, 0);
    tick();
    chk("t319_x1", bus.pipe1x, 2);
    chk("t319_score", bus.current_score, 1);
    tick();
    chk("t320_x1", bus.pipe1x, 0);
    tick();
    chk("t321_x1", bus.pipe1x, 638);
    chk("t321_y1", bus.pipe1ycenter, 202);
    chk("t321_score", bus.current_score, 1);
    for (int t = 0; t < 269; t++) tick();
    chk("pre_halt_x1", bus.pipe1x, 100);
    cyc(1, 0, 1, 0);
    chk("halt_x1", bus.pipe1x, 100);
    chk("halt_run", 32'(bus.running), 0);
    for (int t = 0; t < 3; t++) tick();
    cyc(0, 0, 1, 0);
    chk("stopped_x1", bus.pipe1x, 100);
    cyc(0, 1, 1, 0);
    lit_init("restart");
    for (int t = 0; t < 5; t++) tick();
    chk("rerun_x1", bus.pipe1x, 630);
    cyc(1, 0, 0, 1);
    chk("rst_x1", bus.pipe1x, 0);
    chk("rst_y1", bus.pipe1ycenter, 0);
    chk("rst_score", bus.current_score, 0);
    chk("rst_run", 32'(bus.running), 0);
    cyc(1, 0, 0, 0);
    chk("post_rst_x1", bus.pipe1x, 0);
    cyc(0, 1, 0, 0);
    lit_init("rst_start");
    tick();
    en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_scroller.md
PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, sets the horizontal respawn base in pixels.
REQ-002 Parameter PIPE_WIDTH, default 57, is the pipe width in pixels.
REQ-003 Parameter PIPE_SPACING, default 160, is the left-edge distance between consecutive pipes.
REQ-004 Parameter SCROLL_SPEED, default 2, is the number of pixels moved per frame_tick.
REQ-005 Parameter GAP_MIN_Y, default 160, is the minimum bottom-pipe top y.
REQ-006 Parameter GAP_HEIGHT, default 100, is the constant gap height.
REQ-007 Parameter BIRD_LEFT_EDGE, default 60, is the scoring x line.
REQ-008 Parameter LFSR_SEED, default 8'hA5, is a nonzero LFSR seed.
REQ-009 The module SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-010 Ports SHALL be as follows:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- start  in  1  begin or restart game
- halt  in  1  collision or stop request
- pipe1x..pipe4x  out  32 each  pipe left edge
- pipe1ycenter..pipe4ycenter  out  32 each  bottom-pipe top y
- pipe1yspace..pipe4yspace  out  32 each  gap height
- current_score  out  32  pipes passed
- running  out  1  high in RUN

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and STOPPED, and all outputs SHALL be registered.
REQ-012 In IDLE, every 32-bit output and running SHALL be 0; frame_tick and halt are ignored.
REQ-013 In IDLE or STOPPED, start SHALL enter RUN on the next edge and initialise the playfield.
- pipe_i x = SCREEN_WIDTH + (i-1)*PIPE_SPACING, giving 640/800/960/1120
- pipe_i yspace = GAP_HEIGHT
- current_score = 0
- LFSR reloaded with LFSR_SEED
REQ-014 During initialisation, pipe_i ycenter SHALL be GAP_MIN_Y + (L_i >> 1).
- L_1 = LFSR_SEED
- L_2..L_4 = successive LFSR steps
- the LFSR holds L_4's successor afterwards
REQ-015 The LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, and SHALL step only on initialisation and on respawn.
REQ-016 In RUN, on frame_tick, each pipe SHALL update by one rule:
- x >= SCROLL_SPEED: x = x - SCROLL_SPEED
- x < SCROLL_SPEED (respawn): x = x + 4*PIPE_SPACING - SCROLL_SPEED; ycenter = GAP_MIN_Y + (LFSR >> 1); LFSR steps once
REQ-017 If more than one pipe respawns on the same tick, pipes SHALL consume LFSR values in index order, 1 to 4.
REQ-018 In RUN, on frame_tick, current_score SHALL increment once per pipe where (old x + PIPE_WIDTH >= BIRD_LEFT_EDGE) and (new x + PIPE_WIDTH < BIRD_LEFT_EDGE), computed in 32 bits and saturating at 32'hFFFF_FFFF.
REQ-019 Respawn moves SHALL never count toward the score.
REQ-020 Updated values SHALL be visible on the cycle after the frame_tick edge, with 1-cycle latency.
REQ-021 halt in RUN SHALL enter STOPPED; halt coincident with frame_tick SHALL win, with no position or score update that cycle.
REQ-022 STOPPED SHALL hold all pipe, score and LFSR values frozen; running = 0.
REQ-023 start while in RUN SHALL be ignored.
REQ-024 start and halt together in IDLE or STOPPED SHALL be treated as start.
REQ-025 Outputs SHALL be zero-extended; x never goes negative and never exceeds 4*PIPE_SPACING + SCREEN_WIDTH.

Reset
REQ-026 reset SHALL be sampled on clk and override all other inputs, including mid-RUN.
REQ-027 On reset, the FSM SHALL go to IDLE, all outputs to 0, running to 0, and the LFSR to LFSR_SEED.
REQ-028 One cycle after reset deasserts with no start, outputs SHALL remain 0.

Verification
REQ-029 The bench SHALL cover reset then a start pulse -> next cycle:
- running=1
- pipe1x..pipe4x = 640/800/960/1120
- pipe1ycenter = 242
- all yspace = 100
- score = 0
REQ-030 The bench SHALL cover 319 frame_ticks after start -> pipe1x=2, current_score=1; at tick 318, pipe1x=4 and score=0.
REQ-031 The bench SHALL cover ticks 320 and 321 -> pipe1x=0, then respawn to 638 with pipe1ycenter = GAP_MIN_Y + (LFSR>>1) per the golden model; score stays 1.
REQ-032 The bench SHALL cover halt together with frame_tick at pipe1x=100 -> STOPPED, pipe1x stays 100, running=0; further frame_ticks cause no change.
REQ-033 The bench SHALL cover start from STOPPED -> playfield reinitialised exactly as in REQ-029, score = 0.
REQ-034 The bench SHALL cover reset asserted mid-RUN coincident with frame_tick -> next cycle all outputs 0 and state IDLE.
